// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs RATIO narrow valid/ready beats into one async-FIFO
// word and drives the FIFO write port, stalling while the FIFO is full.
// A beat with in_last flushes a partially packed word; unused lanes are zero.
//
// Build option: define PACK_MSB_FIRST_EN to place the first beat in the top
// lane and fill downward (flush padding then sits in the low lanes).
//
// Ports:
//   wclk          write-domain clock, rising edge
//   rst_n         asynchronous reset, active-low
//   in_valid      input beat valid
//   in_ready      block can accept a beat this cycle
//   in_data       input beat payload (IN_WIDTH)
//   in_last       last beat of a message; flushes the word being packed
//   fifo_full     registered full flag from the FIFO write side
//   wr_en         FIFO write strobe
//   wr_data       FIFO write word (DATA_SIZE)
//   words_written FIFO writes performed, wrapping 16-bit count
//   flush_cnt     partial words flushed by in_last, wrapping 16-bit count
module fifo_wr_packer #(
   parameter int IN_WIDTH  = 8,
   parameter int RATIO     = 4,
   parameter int DATA_SIZE = IN_WIDTH * RATIO
) (
   input  logic                 wclk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_last,
   input  logic                 fifo_full,
   output logic                 wr_en,
   output logic [DATA_SIZE-1:0] wr_data,
   output logic [15:0]          words_written,
   output logic [15:0]          flush_cnt
);
   localparam int LW = $clog2(RATIO);
   localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
   logic [DATA_SIZE-1:0] acc_q, acc_d, out_q, out_d, merged;
   logic [LW-1:0]        lane_q, lane_d, pos;
   logic                 vld_q, vld_d;
   logic [15:0]          ww_q, ww_d, fc_q, fc_d;
   logic                 accept, complete;

   assign wr_en         = vld_q & ~fifo_full;
   // The output slot frees on this same edge whenever a write happens, so a
   // completing beat can reload it with no bubble.
   assign in_ready      = ~vld_q | ~fifo_full;
   assign wr_data       = out_q;
   assign words_written = ww_q;
   assign flush_cnt     = fc_q;
   assign accept        = in_valid & in_ready;
   assign complete      = accept & (in_last | (lane_q == LAST_LANE));

`ifdef PACK_MSB_FIRST_EN
   assign pos = LAST_LANE - lane_q;
`else
   assign pos = lane_q;
`endif

   // acc only ever holds lanes already written for the current word, so the
   // lanes not yet reached are zero and give the flush padding for free.
   always_comb begin
      merged = acc_q;
      merged[pos*IN_WIDTH +: IN_WIDTH] = in_data;
      acc_d  = complete ? '0 : (accept ? merged : acc_q);
      lane_d = complete ? '0 : (accept ? lane_q + 1'b1 : lane_q);
      out_d  = complete ? merged : out_q;
      vld_d  = complete | (vld_q & ~wr_en);
      ww_d   = ww_q + {15'd0, wr_en};
      fc_d   = fc_q + {15'd0, complete & in_last & (lane_q != LAST_LANE)};
   end

   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         lane_q <= '0;
         out_q  <= '0;
         vld_q  <= 1'b0;
         ww_q   <= '0;
         fc_q   <= '0;
      end else begin
         acc_q  <= acc_d;
         lane_q <= lane_d;
         out_q  <= out_d;
         vld_q  <= vld_d;
         ww_q   <= ww_d;
         fc_q   <= fc_d;
      end
   end
endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
Write-domain front end for the async FIFO. It accepts a narrow valid/ready stream, packs RATIO input beats into one FIFO word, and drives wr_en/wr_data into the FIFO write port, stalling on fifo_full. A beat marked in_last flushes a partially filled word, with the unused lanes set to zero. The block runs entirely on wclk.

Parameters:
IN_WIDTH, 8, width of one input beat (bits).
RATIO, 4, input beats per FIFO word; legal values 2..16.
DATA_SIZE, IN_WIDTH*RATIO, FIFO word width; must match the FIFO DATA_SIZE.

Ports:
wclk  input  1  write-domain clock; all logic on its rising edge.
rst_n  input  1  asynchronous reset, active-low.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  IN_WIDTH  input beat payload.
in_last  input  1  final beat of a message; forces a flush of the word being packed.
fifo_full  input  1  registered full flag from the FIFO write side.
wr_en  output  1  FIFO write strobe.
wr_data  output  DATA_SIZE  FIFO write word.
words_written  output  16  count of FIFO writes performed; wraps at 65535 -> 0.
flush_cnt  output  16  count of partial words flushed by in_last; wraps.

Behaviour:
- Storage: accumulator acc[DATA_SIZE], lane index lane_idx (0..RATIO-1), output register out_data[DATA_SIZE], and out_vld.
- Reset values: acc=0, lane_idx=0, out_data=0, out_vld=0, words_written=0, flush_cnt=0. Outputs follow: in_ready=1, wr_en=0, wr_data=0.
- Reset asserted mid-operation clears everything immediately; any partially packed or pending word is discarded.
- wr_en = out_vld & ~fifo_full (combinational). wr_data = out_data at all times.
- A write is accepted on each edge where wr_en=1. That edge clears out_vld, unless a new word loads on the same edge.
- in_ready = ~out_vld | ~fifo_full (combinational). A beat is accepted on an edge where in_valid & in_ready.
- Accepted beat, not completing: in_data is written to lane lane_idx of acc (lane k = bits [k*IN_WIDTH +: IN_WIDTH]), then lane_idx increments.
- A beat completes the word when lane_idx==RATIO-1 or in_last=1. On a completing beat:
  - out_data <= acc merged with the beat; lanes above lane_idx are zero.
  - out_vld <= 1.
  - acc <= 0 and lane_idx <= 0.
- Partial flush: in_last with lane_idx<RATIO-1 also increments flush_cnt. in_last on the beat at lane RATIO-1 is a full word and does not increment flush_cnt.
- Simultaneous events: a FIFO write and a completing beat on the same edge leave out_vld=1 with the new data. No bubble, so sustained throughput is one word per RATIO beats.
- Latency: the completing beat at edge N gives out_vld=1 after edge N. wr_en rises in that cycle if fifo_full=0, and the write occurs at edge N+1.
- Stall: while fifo_full=1 and out_vld=1, wr_data holds stable, wr_en=0, in_ready=0, and acc/lane_idx are frozen.
- words_written increments on every accepted write.
- in_valid=0 leaves all state unchanged. No timeout flush exists; a partial word waits for more beats or for in_last.

Optional Feature:
Macro PACK_MSB_FIRST_EN.
- Undefined: the first beat goes to lane 0 (LSBs) and lanes fill upward; flush padding occupies the high lanes.
- Defined: the first beat goes to lane RATIO-1 (MSBs) and lanes fill downward, i.e. lane = RATIO-1-lane_idx; flush padding occupies the low lanes.
- Counters, handshake and timing are identical in both builds.

Test Plan:
1. Reset: rst_n=0 with in_valid=1 -> wr_en=0, in_ready=1, wr_data=0, both counters 0.
2. Full packing: beats 0x11,0x22,0x33,0x44 back-to-back, fifo_full=0 -> one write with wr_data=0x44332211 the cycle after the 4th beat; words_written=1.
3. Partial flush: beats 0xAA,0xBB with in_last on 0xBB -> wr_data=0x0000BBAA; flush_cnt=1. Repeat with the macro defined -> wr_data=0xAABB0000.
4. Back-pressure: hold fifo_full=1 after a word completes, then stream 8 beats -> in_ready=0, wr_data stable, no write. Release -> two words 0x44332211 and 0x88776655 written in order, nothing lost.
5. Streaming: 64 consecutive beats, fifo_full=0 -> in_ready stays 1, 16 writes with no bubbles, words_written=16.
6. Reset mid-word: 3 beats accepted, pulse rst_n low -> then 4 beats 0x01..0x04 -> single write 0x04030201; no stale lanes.
